// File: rtl/qupls_checkpoint_valid_writer.sv
// qupls_checkpoint_valid_writer
// Write-side sequencer for the checkpoint valid-bit RAM. Register valid-bit
// events from writeback/rename are queued in a FIFO and drained oldest-first
// onto the RAM write ports (oldest entry on the lowest port, so the younger
// write wins an address collision). A sweep FSM initialises every physical
// register's bit for a newly allocated checkpoint; draining is held off for
// the whole sweep so queued events land after it and override sweep values.
// Optional build macro QUPLS_CVW_STATS_EN adds write/stall statistic counters.
module qupls_checkpoint_valid_writer #(
    parameter int NPORT      = 8,
    parameter int NEV        = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int PREGS      = 256,
    parameter int NCHECK     = 16,
    localparam int CPW       = $clog2(NCHECK),
    localparam int PW        = $clog2(PREGS)
) (
    input  logic                 clka,
    input  logic                 rst,
    input  logic [NEV-1:0]       ev_valid,
    input  logic [NEV*CPW-1:0]   ev_cp,
    input  logic [NEV*PW-1:0]    ev_preg,
    input  logic [NEV-1:0]       ev_val,
    output logic                 ev_ready,
    input  logic                 init_req,
    input  logic [CPW-1:0]       init_cp,
    input  logic                 init_val,
    output logic                 init_busy,
    output logic                 init_done,
    output logic [NPORT-1:0]     wr,
    output logic [NPORT*CPW-1:0] wc,
    output logic [NPORT*PW-1:0]  wa,
    output logic [NPORT-1:0]     i,
    output logic [NPORT-1:0]     setall
`ifdef QUPLS_CVW_STATS_EN
    ,
    output logic [31:0]          stat_writes,
    output logic [31:0]          stat_stalls
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    typedef logic [AW:0] cnt_t;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t               state, state_next;
    logic [PW-1:0]        base;
    logic [CPW-1:0]       sw_cp;
    logic                 sw_val;

    logic [CPW-1:0]       fifo_cp   [FIFO_DEPTH];
    logic [PW-1:0]        fifo_preg [FIFO_DEPTH];
    logic                 fifo_val  [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    cnt_t                 count, count_next, valid_cnt, push_cnt, pop_cnt, free_next;
    logic [AW-1:0]        push_off [NEV];
    logic                 ready_next;

    logic [NPORT-1:0]     wr_d, i_d;
    logic [NPORT*CPW-1:0] wc_d;
    logic [NPORT*PW-1:0]  wa_d;

    assign setall    = '0;
    assign init_busy = (state != IDLE);
    assign init_done = (state == DONE);

    // Sweep sequencer next state: one sweep pass, then a single DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (init_req) state_next = SWEEP;
            SWEEP:   if (base == PW'(PREGS - NPORT)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FIFO bookkeeping: compact valid events into consecutive slots and pick
    // how many entries to pop. An accepted init_req also holds off draining so
    // nothing queued before the sweep can be overwritten by it.
    always_comb begin
        valid_cnt = '0;
        for (int k = 0; k < NEV; k++) begin
            push_off[k] = valid_cnt[AW-1:0];
            if (ev_valid[k]) valid_cnt = valid_cnt + cnt_t'(1);
        end
        push_cnt = ev_ready ? valid_cnt : '0;
        pop_cnt  = '0;
        if (state == IDLE && !init_req)
            pop_cnt = (count > cnt_t'(NPORT)) ? cnt_t'(NPORT) : count;
        count_next = count + push_cnt - pop_cnt;
        free_next  = cnt_t'(FIFO_DEPTH) - count_next;
        ready_next = (free_next >= cnt_t'(NEV));
    end

    // Next write-port contents: either a full row of the sweep or the popped
    // FIFO entries, oldest on port 0.
    always_comb begin
        wr_d = '0;
        wc_d = '0;
        wa_d = '0;
        i_d  = '0;
        if (state == SWEEP) begin
            wr_d = '1;
            for (int n = 0; n < NPORT; n++) begin
                wc_d[n*CPW +: CPW] = sw_cp;
                wa_d[n*PW +: PW]   = base + PW'(n);
                i_d[n]             = sw_val;
            end
        end else begin
            for (int n = 0; n < NPORT; n++) begin
                if (cnt_t'(n) < pop_cnt) begin
                    wr_d[n]            = 1'b1;
                    wc_d[n*CPW +: CPW] = fifo_cp[rd_ptr + AW'(n)];
                    wa_d[n*PW +: PW]   = fifo_preg[rd_ptr + AW'(n)];
                    i_d[n]             = fifo_val[rd_ptr + AW'(n)];
                end
            end
        end
    end

    // ---- stage boundary: control state and registered RAM write ports ----
    // Control and port registers; reset aborts any sweep and drops the queue.
    always_ff @(posedge clka) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ev_ready <= 1'b1;
            wr       <= '0;
            wc       <= '0;
            wa       <= '0;
            i        <= '0;
        end else begin
            state    <= state_next;
            base     <= (state == SWEEP) ? base + PW'(NPORT) : '0;
            wr_ptr   <= wr_ptr + push_cnt[AW-1:0];
            rd_ptr   <= rd_ptr + pop_cnt[AW-1:0];
            count    <= count_next;
            ev_ready <= ready_next;
            wr       <= wr_d;
            wc       <= wc_d;
            wa       <= wa_d;
            i        <= i_d;
        end
    end

    // Capture the sweep target and value when a sweep is accepted.
    always_ff @(posedge clka) begin
        if (state == IDLE && init_req) begin
            sw_cp  <= init_cp;
            sw_val <= init_val;
        end
    end

    // FIFO storage write; entries carry no reset, the pointers define validity.
    always_ff @(posedge clka) begin
        for (int k = 0; k < NEV; k++) begin
            if (ev_ready && ev_valid[k]) begin
                fifo_cp[wr_ptr + push_off[k]]   <= ev_cp[k*CPW +: CPW];
                fifo_preg[wr_ptr + push_off[k]] <= ev_preg[k*PW +: PW];
                fifo_val[wr_ptr + push_off[k]]  <= ev_val[k];
            end
        end
    end

`ifdef QUPLS_CVW_STATS_EN
    // Statistics: total RAM write strobes and cycles where events were refused.
    always_ff @(posedge clka) begin
        if (rst) begin
            stat_writes <= '0;
            stat_stalls <= '0;
        end else begin
            stat_writes <= stat_writes + 32'($countones(wr));
            if (|ev_valid && !ev_ready) stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qupls_checkpoint_valid_writer.sv
// Scoreboard bench for qupls_checkpoint_valid_writer: stimulus pushes the
// expected RAM writes in program order; a monitor pops one per asserted wr bit.
module tb_qupls_checkpoint_valid_writer;
    localparam int NPORT = 8;
    localparam int NEV   = 4;

    logic                 clka = 1'b0;
    logic                 rst;
    logic [NEV-1:0]       ev_valid;
    logic [NEV*4-1:0]     ev_cp;
    logic [NEV*8-1:0]     ev_preg;
    logic [NEV-1:0]       ev_val;
    logic                 ev_ready;
    logic                 init_req;
    logic [3:0]           init_cp;
    logic                 init_val;
    logic                 init_busy;
    logic                 init_done;
    logic [NPORT-1:0]     wr;
    logic [NPORT*4-1:0]   wc;
    logic [NPORT*8-1:0]   wa;
    logic [NPORT-1:0]     i;
    logic [NPORT-1:0]     setall;
`ifdef QUPLS_CVW_STATS_EN
    logic [31:0]          stat_writes;
    logic [31:0]          stat_stalls;
`endif

    always #5 clka = ~clka;

    qupls_checkpoint_valid_writer dut (
        .clka(clka), .rst(rst),
        .ev_valid(ev_valid), .ev_cp(ev_cp), .ev_preg(ev_preg), .ev_val(ev_val),
        .ev_ready(ev_ready),
        .init_req(init_req), .init_cp(init_cp), .init_val(init_val),
        .init_busy(init_busy), .init_done(init_done),
        .wr(wr), .wc(wc), .wa(wa), .i(i), .setall(setall)
`ifdef QUPLS_CVW_STATS_EN
        , .stat_writes(stat_writes), .stat_stalls(stat_stalls)
`endif
    );

    typedef struct packed {
        logic [3:0] cp;
        logic [7:0] preg;
        logic       val;
    } wrec_t;

    wrec_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    wrec_t mon_got;
    wrec_t mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every asserted wr bit must match the next expected write.
    always @(negedge clka) begin
        if (wr !== '0) begin
            check("wr_low_contiguous", 32'(wr & (wr + 8'd1)), 32'd0);
            for (int p = 0; p < NPORT; p++) begin
                if (wr[p]) begin
                    mon_got = '{wc[p*4 +: 4], wa[p*8 +: 8], i[p]};
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: port %0d got cp=%0d preg=%0d val=%0d, required no write",
                                 p, mon_got.cp, mon_got.preg, mon_got.val);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("port_write", 32'(mon_got), 32'(mon_exp));
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic set_ev(input int k, input int cp, input int preg, input logic v);
        logic [3:0] c4;
        logic [7:0] p8;
        c4 = cp[3:0];
        p8 = preg[7:0];
        ev_valid[k]       = 1'b1;
        ev_cp[k*4 +: 4]   = c4;
        ev_preg[k*8 +: 8] = p8;
        ev_val[k]         = v;
        exp_q.push_back('{c4, p8, v});
    endtask

    task automatic clear_ev();
        ev_valid = '0;
    endtask

    task automatic exp_sweep(input int cp, input logic v);
        logic [7:0] a8;
        for (int a = 0; a < 256; a++) begin
            a8 = a[7:0];
            exp_q.push_back('{cp[3:0], a8, v});
        end
    endtask

    task automatic wait_write(input string name);
        int c;
        c = 0;
        while (wr == '0 && c < 10) begin
            tick();
            c++;
        end
        if (wr == '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no write, required a write within 10 cycles", name);
        end
    endtask

    task automatic drain_wait(input string name);
        for (int c = 0; c < 400; c++) begin
            if (exp_q.size() == 0 && !init_busy && wr == '0) break;
            tick();
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int busy_n;
        int done_n;
        int wr_cycles;

        rst = 1'b1; ev_valid = '0; ev_cp = '0; ev_preg = '0; ev_val = '0;
        init_req = 1'b0; init_cp = '0; init_val = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_ev_ready", 32'(ev_ready), 32'd1);
        check("rst_init_busy", 32'(init_busy), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_wc_wa_i_zero", 32'((wc == '0) && (wa == '0) && (i == '0)), 32'd1);
        check("setall_zero", 32'(setall), 32'd0);
        rst = 1'b0;
        tick();

        // 1) three events in one cycle land on ports 0..2
        set_ev(0, 2, 5, 1'b1);
        set_ev(1, 2, 6, 1'b0);
        set_ev(2, 3, 5, 1'b1);
        tick();
        clear_ev();
        wait_write("t1");
        check("t1_wr", 32'(wr), 32'h07);
        check("t1_wa", 32'(wa[23:0]), {8'd0, 8'd5, 8'd6, 8'd5});
        check("t1_wc", 32'(wc[11:0]), {20'd0, 4'd3, 4'd2, 4'd2});
        check("t1_i", 32'(i[2:0]), 32'b101);
        drain_wait("t1_drained");

        // 2) four events per cycle for five cycles; FIFO never fills
        for (int c = 0; c < 5; c++) begin
            check("t2_ready", 32'(ev_ready), 32'd1);
            for (int k = 0; k < NEV; k++) set_ev(k, c, 20 + c*4 + k, k[0]);
            tick();
        end
        clear_ev();
        drain_wait("t2_drained");

        // 3) sweep cp=7 val=1, with an ignored second request mid-sweep
        exp_sweep(7, 1'b1);
        init_req = 1'b1; init_cp = 4'd7; init_val = 1'b1;
        tick();
        init_req = 1'b0; init_cp = 4'd3; init_val = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int c = 0; c < 100; c++) begin
            if (!init_busy) break;
            busy_n++;
            if (init_done) done_n++;
            init_req = (c == 10);
            tick();
        end
        init_req = 1'b0;
        check("t3_busy_cycles", 32'(busy_n), 32'd33);
        check("t3_done_pulses", 32'(done_n), 32'd1);
        drain_wait("t3_drained");

        // 4) fill the FIFO while a sweep runs; events follow the sweep
        exp_sweep(4, 1'b0);
        init_req = 1'b1; init_cp = 4'd4; init_val = 1'b0;
        for (int k = 0; k < NEV; k++) set_ev(k, 9, 100 + k, k[0]);
        tick();
        init_req = 1'b0;
        for (int c = 1; c < 4; c++) begin
            check("t4_ready_before_full", 32'(ev_ready), 32'd1);
            for (int k = 0; k < NEV; k++) set_ev(k, 9, 100 + c*4 + k, k[0]);
            tick();
        end
        clear_ev();
        check("t4_ready_full", 32'(ev_ready), 32'd0);
        check("t4_still_busy", 32'(init_busy), 32'd1);
        drain_wait("t4_drained");
        check("t4_ready_after", 32'(ev_ready), 32'd1);

        // 5) same-cycle collision: port order keeps the younger write on top
        set_ev(0, 1, 9, 1'b0);
        set_ev(1, 1, 9, 1'b1);
        tick();
        clear_ev();
        wait_write("t5");
        check("t5_wr", 32'(wr), 32'h03);
        check("t5_wa", 32'(wa[15:0]), {16'd0, 8'd9, 8'd9});
        check("t5_i", 32'(i[1:0]), 32'b10);
        drain_wait("t5_drained");

        // 6) reset mid-sweep with queued events: everything is dropped
        exp_sweep(2, 1'b1);
        init_req = 1'b1; init_cp = 4'd2; init_val = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < NEV; k++) set_ev(k, 5, 200 + k, 1'b1);
        tick();
        set_ev(0, 5, 210, 1'b0);
        tick();
        clear_ev();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        check("t6_wr", 32'(wr), 32'd0);
        check("t6_busy", 32'(init_busy), 32'd0);
        check("t6_done", 32'(init_done), 32'd0);
        check("t6_ready", 32'(ev_ready), 32'd1);
        rst = 1'b0;
        wr_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (wr != '0) wr_cycles++;
        end
        check("t6_no_writes_after_rst", 32'(wr_cycles), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
